// File: rtl/tt_sel_seq.sv
// -----------------------------------------------------------------------------
// tt_sel_seq -- clocked selection and enable sequencer for the mux fabric.
//
// The raw pad controls are synchronised and then drive two things:
//  * a mask-aware select counter (branch, block). It skips unpopulated branches
//    and wraps past the highest populated branch back to the lowest one.
//  * a four-state enable sequencer (OFF, PWRUP, ON, PWRDN). It raises the
//    power gate PG_DELAY cycles before the functional enable. After the enable
//    drops, it holds the power gate for PD_HOLD more cycles.
//
// Ports:
//   clk             in   system clock
//   rst             in   synchronous active-high reset
//   ctrl_sel_rst_n  in   raw pad, low clears the address
//   ctrl_sel_inc    in   raw pad, each rising edge advances the address
//   ctrl_ena        in   raw pad, requests enable of the selected module
//   sel_branch      out  selected branch index (never a masked branch)
//   sel_block       out  selected block within the branch
//   um_pg_ena       out  power-gate enable for the selected module (registered)
//   um_ena          out  functional enable for the selected module (registered)
//   busy            out  high while powering up or powering down (registered)
// -----------------------------------------------------------------------------
module tt_sel_seq #(
   parameter int                  G_X         = 16,
   parameter int                  G_Y         = 24,
   parameter logic [G_Y-1:0]      MUX_MASK    = '0,
   parameter int                  PG_DELAY    = 8,
   parameter int                  PD_HOLD     = 2,
   parameter int                  SYNC_STAGES = 2,
   localparam int                 BW          = $clog2(G_Y),
   localparam int                 XW          = $clog2(G_X)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ctrl_sel_rst_n,
   input  logic          ctrl_sel_inc,
   input  logic          ctrl_ena,
   output logic [BW-1:0] sel_branch,
   output logic [XW-1:0] sel_block,
   output logic          um_pg_ena,
   output logic          um_ena,
   output logic          busy
);

   // ---------------------------------------------------------------------
   // Parameter sanity checks, caught at elaboration time
   // ---------------------------------------------------------------------
   if (MUX_MASK == {G_Y{1'b1}}) begin : g_bad_mask
      $error("tt_sel_seq: MUX_MASK leaves no populated branch");
   end
   if (G_X < 2 || G_Y < 2) begin : g_bad_grid
      $error("tt_sel_seq: G_X and G_Y must both be >= 2");
   end
   if (PG_DELAY < 1 || PD_HOLD < 1 || SYNC_STAGES < 2) begin : g_bad_timing
      $error("tt_sel_seq: PG_DELAY, PD_HOLD >= 1 and SYNC_STAGES >= 2 required");
   end

   // Lowest populated branch; this is the home address after reset or clear.
   function automatic logic [BW-1:0] first_unmasked(input logic [G_Y-1:0] mask);
      logic [BW-1:0] r;
      r = '0;
      for (int i = G_Y - 1; i >= 0; i--) begin
         if (!mask[i]) r = BW'(i);
      end
      return r;
   endfunction

   localparam logic [BW-1:0] F_BR     = first_unmasked(MUX_MASK);
   localparam logic [XW-1:0] LAST_BLK = XW'(G_X - 1);
   localparam int            CMAX     = (PG_DELAY > PD_HOLD) ? PG_DELAY : PD_HOLD;
   localparam int            CW       = $clog2(CMAX + 1);

   // ---------------------------------------------------------------------
   // Pad synchronisers. The reset values make an idle pad look inactive.
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] rstn_sync_reg;
   logic [SYNC_STAGES-1:0] inc_sync_reg;
   logic [SYNC_STAGES-1:0] ena_sync_reg;
   logic                   inc_prev_reg;
   logic                   sel_rst_n_s;
   logic                   inc_s;
   logic                   ena_s;
   logic                   inc_pulse;

   always_ff @(posedge clk) begin
      if (rst) begin
         rstn_sync_reg <= '1;
         inc_sync_reg  <= '0;
         ena_sync_reg  <= '0;
         inc_prev_reg  <= 1'b0;
      end else begin
         rstn_sync_reg <= {rstn_sync_reg[SYNC_STAGES-2:0], ctrl_sel_rst_n};
         inc_sync_reg  <= {inc_sync_reg[SYNC_STAGES-2:0],  ctrl_sel_inc};
         ena_sync_reg  <= {ena_sync_reg[SYNC_STAGES-2:0],  ctrl_ena};
         inc_prev_reg  <= inc_s;
      end
   end

   assign sel_rst_n_s = rstn_sync_reg[SYNC_STAGES-1];
   assign inc_s       = inc_sync_reg[SYNC_STAGES-1];
   assign ena_s       = ena_sync_reg[SYNC_STAGES-1];
   assign inc_pulse   = inc_s & ~inc_prev_reg;

   // ---------------------------------------------------------------------
   // Address register with a single-cycle next-populated-branch search
   // ---------------------------------------------------------------------
   logic [BW-1:0]  branch_reg, branch_next, branch_prev_reg, branch_up;
   logic [XW-1:0]  block_reg, block_next, block_prev_reg;
   logic [G_Y-1:0] above;
   logic           found;
   logic           addr_chg;

   // above[gi]: branch gi is populated and lies strictly above the current one.
   for (genvar gi = 0; gi < G_Y; gi++) begin : g_above
      assign above[gi] = !MUX_MASK[gi] && (BW'(gi) > branch_reg);
   end

   // Lowest set bit of 'above'. If no bit is set, wrap back to the home branch.
   always_comb begin
      branch_up = F_BR;
      found     = 1'b0;
      for (int i = 0; i < G_Y; i++) begin
         if (above[i] && !found) begin
            branch_up = BW'(i);
            found     = 1'b1;
         end
      end
   end

   // When both arrive together, the clear wins over the increment.
   always_comb begin
      branch_next = branch_reg;
      block_next  = block_reg;
      if (!sel_rst_n_s) begin
         branch_next = F_BR;
         block_next  = '0;
      end else if (inc_pulse) begin
         if (block_reg == LAST_BLK) begin
            block_next  = '0;
            branch_next = branch_up;
         end else begin
            block_next  = block_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         branch_reg      <= F_BR;
         block_reg       <= '0;
         branch_prev_reg <= F_BR;
         block_prev_reg  <= '0;
      end else begin
         branch_reg      <= branch_next;
         block_reg       <= block_next;
         branch_prev_reg <= branch_reg;
         block_prev_reg  <= block_reg;
      end
   end

   assign addr_chg   = (branch_reg != branch_prev_reg) || (block_reg != block_prev_reg);
   assign sel_branch = branch_reg;
   assign sel_block  = block_reg;

   // ---------------------------------------------------------------------
   // Enable sequencer
   // ---------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_PWRUP = 2'd1,
      ST_ON    = 2'd2,
      ST_PWRDN = 2'd3
   } state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          pg_reg, pg_next;
   logic          ena_reg, ena_next;
   logic          busy_reg, busy_next;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      unique case (state_reg)
         ST_OFF: begin
            // A pending address change is allowed to settle before power-up.
            if (ena_s && !addr_chg) begin
               state_next = ST_PWRUP;
               cnt_next   = '0;
            end
         end
         ST_PWRUP: begin
            // An abort takes priority over completing the power-up.
            if (!ena_s || addr_chg) begin
               state_next = ST_PWRDN;
               cnt_next   = '0;
            end else if (cnt_reg == CW'(PG_DELAY - 1)) begin
               state_next = ST_ON;
               cnt_next   = '0;
            end else begin
               cnt_next   = cnt_reg + 1'b1;
            end
         end
         ST_ON: begin
            if (!ena_s || addr_chg) begin
               state_next = ST_PWRDN;
               cnt_next   = '0;
            end
         end
         ST_PWRDN: begin
            // The hold ignores address changes; OFF re-evaluates the request.
            if (cnt_reg == CW'(PD_HOLD - 1)) begin
               state_next = ST_OFF;
               cnt_next   = '0;
            end else begin
               cnt_next   = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = ST_OFF;
            cnt_next   = '0;
         end
      endcase

      // The outputs are decoded from the next state and registered, so they
      // change on the same edge as the state register.
      pg_next   = (state_next != ST_OFF);
      ena_next  = (state_next == ST_ON);
      busy_next = (state_next == ST_PWRUP) || (state_next == ST_PWRDN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_OFF;
         cnt_reg   <= '0;
         pg_reg    <= 1'b0;
         ena_reg   <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         pg_reg    <= pg_next;
         ena_reg   <= ena_next;
         busy_reg  <= busy_next;
      end
   end

   assign um_pg_ena = pg_reg;
   assign um_ena    = ena_reg;
   assign busy      = busy_reg;

endmodule
